data_sync_bus: RTL and testbench

- Multi-flop (MCF) bus synchronizer for single-clock-destination CDC.
- Takes a multi-bit bus and its qualifying enable from a foreign clock domain.
- Synchronizes only the enable through a NUM_STAGES flop chain and derives a one-cycle enable pulse.
- Captures the bus into a destination-domain register on that pulse. The source must hold the bus stable while the enable is in flight.

---
 rtl/data_sync_bus.sv | 62 ++++++
 tb/tb_data_sync_bus.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_bus.sv
// Multi-flop bus synchronizer: the enable crosses through a NUM_STAGES chain and its
// rising edge captures the held source bus. Optional sync_valid flag via SYNC_BUS_VALID_EN.
module data_sync_bus #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
`ifdef SYNC_BUS_VALID_EN
  ,
  output logic                 sync_valid
`endif
);

  logic [NUM_STAGES-1:0] r_sync_chain;
  logic                  r_pulse_ff;
  logic                  w_sync_en;
  logic                  w_pulse_comb;

  // Enable synchronizer chain; only the enable crosses, the bus is assumed quiet
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync_chain <= '0;
    end else begin
      r_sync_chain <= {r_sync_chain[NUM_STAGES-2:0], bus_enable};
    end
  end

  assign w_sync_en    = r_sync_chain[NUM_STAGES-1];
  assign w_pulse_comb = w_sync_en & ~r_pulse_ff;

  // Rising-edge detect of the synchronized enable, then registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_pulse_ff   <= 1'b0;
      enable_pulse <= 1'b0;
      sync_bus     <= '0;
    end else begin
      r_pulse_ff   <= w_sync_en;
      enable_pulse <= w_pulse_comb;
      if (w_pulse_comb) begin
        sync_bus <= unsync_bus;
      end
    end
  end

`ifdef SYNC_BUS_VALID_EN
  // Sticky flag: at least one word has been captured since reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_valid <= 1'b0;
    end else if (w_pulse_comb) begin
      sync_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_sync_bus.sv
// Scoreboard bench for data_sync_bus: expected words queued at stimulus, popped on enable_pulse.
module tb_data_sync_bus;

  localparam int unsigned NS = 5;
  localparam int unsigned BW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable;
  logic [BW-1:0] sync_bus;
  logic          enable_pulse;
`ifdef SYNC_BUS_VALID_EN
  logic          sync_valid;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [BW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  data_sync_bus #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (unsync_bus),
    .bus_enable   (bus_enable),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse)
`ifdef SYNC_BUS_VALID_EN
    ,
    .sync_valid   (sync_valid)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [BW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Runs n edges, recording the first pulse edge, pulse-high cycles, captured bus,
  // and any sync_bus change outside a pulse cycle.
  task automatic observe(input int n, output int first_edge, output int pulses,
                         output logic [BW-1:0] cap, output int bad_changes,
                         output int valid_early, output int valid_at);
    logic [BW-1:0] prev;
    first_edge = -1; pulses = 0; cap = '0; bad_changes = 0;
    valid_early = 0; valid_at = 0;
    prev = sync_bus;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (enable_pulse === 1'b1) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = e;
          cap = sync_bus;
`ifdef SYNC_BUS_VALID_EN
          valid_at = (sync_valid === 1'b1) ? 1 : 0;
`endif
        end
      end else if (sync_bus !== prev) begin
        bad_changes++;
      end
`ifdef SYNC_BUS_VALID_EN
      if (first_edge < 0 && sync_valid !== 1'b0) valid_early++;
`endif
      prev = sync_bus;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; unsync_bus = 8'hFF; bus_enable = 1'b1;
    tick();
    tests_run++;
    if (sync_bus !== 8'h00) begin
      tests_failed++; $display("FAIL reset_sync_bus: got %h want 00", sync_bus);
    end
    tests_run++;
    if (enable_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulse: got %b want 0", enable_pulse);
    end
`ifdef SYNC_BUS_VALID_EN
    tests_run++;
    if (sync_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", sync_valid);
    end
`endif
  endtask

  task automatic test_basic();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, exp;
    RST = 1'b1; bus_enable = 1'b0; unsync_bus = 8'h00;
    tick(); tick();
    unsync_bus = 8'hAB; bus_enable = 1'b1; exp_q.push_back(8'hAB);
    observe(7, fe, np, cap, bad, ve, va);
    tests_run++;
    if (fe !== int'(NS + 1)) begin
      tests_failed++; $display("FAIL basic_latency: got %0d want %0d", fe, NS + 1);
    end
    tests_run++;
    if (np !== 1) begin
      tests_failed++; $display("FAIL basic_pulse_count: got %0d want 1", np);
    end
    exp = pop_exp();
    tests_run++;
    if (cap !== exp) begin
      tests_failed++; $display("FAIL basic_capture: got %h want %h", cap, exp);
    end
    tests_run++;
    if (bad !== 0 || sync_bus !== 8'hAB) begin
      tests_failed++; $display("FAIL basic_hold: got %h changes %0d want AB", sync_bus, bad);
    end
  endtask

  task automatic test_hold();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap;
    unsync_bus = 8'h12;
    observe(20, fe, np, cap, bad, ve, va);
    tests_run++;
    if (np !== 0) begin
      tests_failed++; $display("FAIL hold_no_pulse: got %0d pulses want 0", np);
    end
    tests_run++;
    if (bad !== 0 || sync_bus !== 8'hAB) begin
      tests_failed++; $display("FAIL hold_bus: got %h changes %0d want AB", sync_bus, bad);
    end
  endtask

  task automatic test_reset_second();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, exp;
    RST = 1'b0;
    tick();
    tests_run++;
    if (sync_bus !== 8'h00 || enable_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset2_clear: got bus %h pulse %b want 00 0", sync_bus, enable_pulse);
    end
    RST = 1'b1; unsync_bus = 8'hCD; bus_enable = 1'b1; exp_q.push_back(8'hCD);
    observe(10, fe, np, cap, bad, ve, va);
    tests_run++;
    if (fe !== int'(NS + 1) || np !== 1) begin
      tests_failed++; $display("FAIL reset2_pulse: got edge %0d count %0d want %0d 1", fe, np, NS + 1);
    end
    exp = pop_exp();
    tests_run++;
    if (cap !== exp || bad !== 0) begin
      tests_failed++; $display("FAIL reset2_capture: got %h changes %0d want %h", cap, bad, exp);
    end
  endtask

  task automatic test_rearm();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, exp;
    bus_enable = 1'b0;
    tick();
    bus_enable = 1'b1; unsync_bus = 8'h5A; exp_q.push_back(8'h5A);
    observe(8, fe, np, cap, bad, ve, va);
    tests_run++;
    if (fe !== int'(NS + 1) || np !== 1) begin
      tests_failed++; $display("FAIL rearm_pulse: got edge %0d count %0d want %0d 1", fe, np, NS + 1);
    end
    exp = pop_exp();
    tests_run++;
    if (cap !== exp || bad !== 0) begin
      tests_failed++; $display("FAIL rearm_capture: got %h changes %0d want %h", cap, bad, exp);
    end
  endtask

  task automatic test_back_to_back();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, exp, d;
    for (int i = 0; i < 4; i++) begin
      d = BW'($urandom);
      bus_enable = 1'b0;
      tick();
      bus_enable = 1'b1; unsync_bus = d; exp_q.push_back(d);
      observe(7, fe, np, cap, bad, ve, va);
      tests_run++;
      if (fe !== int'(NS + 1) || np !== 1) begin
        tests_failed++;
        $display("FAIL b2b_pulse[%0d]: got edge %0d count %0d want %0d 1", i, fe, np, NS + 1);
      end
      exp = pop_exp();
      tests_run++;
      if (cap !== exp || bad !== 0) begin
        tests_failed++; $display("FAIL b2b_capture[%0d]: got %h changes %0d want %h", i, cap, bad, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, held;
    bus_enable = 1'b0;
    observe(8, fe, np, cap, bad, ve, va);
    held = sync_bus;
    tests_run++;
    if (np !== 0 || bad !== 0) begin
      tests_failed++; $display("FAIL fall_no_pulse: got count %0d changes %0d want 0 0", np, bad);
    end
    unsync_bus = ~held;
    #2 bus_enable = 1'b1;
    #2 bus_enable = 1'b0;
    observe(10, fe, np, cap, bad, ve, va);
    tests_run++;
    if (np !== 0 || bad !== 0 || sync_bus !== held) begin
      tests_failed++;
      $display("FAIL glitch_ignored: got count %0d bus %h want 0 %h", np, sync_bus, held);
    end
  endtask

  task automatic test_mid_reset();
    int fe, np, bad, ve, va;
    logic [BW-1:0] cap, exp;
    unsync_bus = 8'h77; bus_enable = 1'b1; exp_q.push_back(8'h77);
    tick(); tick();
    tests_run++;
    if (enable_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_early: got %b want 0", enable_pulse);
    end
    RST = 1'b0;
    tick();
    tests_run++;
    if (sync_bus !== 8'h00 || enable_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got bus %h pulse %b want 00 0", sync_bus, enable_pulse);
    end
    RST = 1'b1;
    observe(10, fe, np, cap, bad, ve, va);
    tests_run++;
    if (fe !== int'(NS + 1) || np !== 1) begin
      tests_failed++; $display("FAIL midrst_pulse: got edge %0d count %0d want %0d 1", fe, np, NS + 1);
    end
    exp = pop_exp();
    tests_run++;
    if (cap !== exp || bad !== 0) begin
      tests_failed++; $display("FAIL midrst_capture: got %h changes %0d want %h", cap, bad, exp);
    end
`ifdef SYNC_BUS_VALID_EN
    tests_run++;
    if (ve !== 0 || va !== 1) begin
      tests_failed++; $display("FAIL midrst_valid: got early %0d at_pulse %0d want 0 1", ve, va);
    end
`endif
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    RST = 1'b0; unsync_bus = '0; bus_enable = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_hold();
    test_reset_second();
    test_rearm();
    test_back_to_back();
    test_glitch();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
